// File: rtl/uart_tx_fifo_core_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_fifo_core_if : host push port and serial/status outputs            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface uart_tx_fifo_core_if;
   logic       wr_en;
   logic [7:0] data;
   logic       tx;
   logic       clk_rx;
   logic       clk_tx;
   logic       full;
   logic       empty;
   logic       busy;

   modport master (
      output wr_en, data,
      input  tx, clk_rx, clk_tx, full, empty, busy
   );

   modport slave (
      input  wr_en, data,
      output tx, clk_rx, clk_tx, full, empty, busy
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_fifo_core : K/N baud divider, byte FIFO and 8N1 (or 8E1 when       |
// | UART_TX_PARITY_EN is defined) serializer, LSB first, idle-high line.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_tx_fifo_core #(
   parameter int K     = 2416,
   parameter int N     = 16,
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   uart_tx_fifo_core_if.slave bus
);

   localparam int RXW = (K > 1) ? $clog2(K) : 1;
   localparam int TXW = (N > 1) ? $clog2(N) : 1;
   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW  = $clog2(DEPTH + 1);

   // ---------------- baud divider ----------------
   logic [RXW-1:0] rx_cnt;
   logic [TXW-1:0] tx_cnt;
   logic           rx_tick;
   logic           tx_tick;

   assign rx_tick = (rx_cnt == RXW'(K - 1));
   assign tx_tick = rx_tick && (tx_cnt == TXW'(N - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_cnt <= '0;
         tx_cnt <= '0;
      end else begin
         if (rx_tick) begin
            rx_cnt <= '0;
            if (tx_cnt == TXW'(N - 1))
               tx_cnt <= '0;
            else
               tx_cnt <= tx_cnt + TXW'(1);
         end else begin
            rx_cnt <= rx_cnt + RXW'(1);
         end
      end
   end

   // ---------------- byte FIFO ----------------
   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1))
         return '0;
      else
         return p + PW'(1);
   endfunction

   // A push while full is dropped even if the FSM pops in the same cycle.
   assign push = bus.wr_en && !full;

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= bus.data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push)
            wr_ptr <= ptr_inc(wr_ptr);
         if (pop)
            rd_ptr <= ptr_inc(rd_ptr);
         count <= count_next;
         full  <= (count_next == CW'(DEPTH));
         empty <= (count_next == '0);
      end
   end

   // ---------------- serializer FSM ----------------
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;
   logic par;
   logic par_n;
`else
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;
`endif

   state_t     state;
   state_t     state_n;
   logic [7:0] sh;
   logic [7:0] sh_n;
   logic [2:0] bit_cnt;
   logic [2:0] bit_n;
   logic       tx_reg;
   logic       tx_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         sh      <= '0;
         bit_cnt <= '0;
         tx_reg  <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par     <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         sh      <= sh_n;
         bit_cnt <= bit_n;
         tx_reg  <= tx_n;
`ifdef UART_TX_PARITY_EN
         par     <= par_n;
`endif
      end
   end

   always_comb begin
      state_n = state;
      sh_n    = sh;
      bit_n   = bit_cnt;
      tx_n    = tx_reg;
      pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_n   = par;
`endif
      if (tx_tick) begin
         case (state)
            S_IDLE: begin
               tx_n = 1'b1;
               if (!empty) begin
                  pop     = 1'b1;
                  sh_n    = mem[rd_ptr];
                  tx_n    = 1'b0;
                  state_n = S_START;
               end
            end
            S_START: begin
               tx_n    = sh[0];
               bit_n   = 3'd0;
               state_n = S_DATA;
`ifdef UART_TX_PARITY_EN
               // Capture parity now, before shifting consumes the byte.
               par_n   = ^sh;
`endif
            end
            S_DATA: begin
               if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  tx_n    = par;
                  state_n = S_PARITY;
`else
                  tx_n    = 1'b1;
                  state_n = S_STOP;
`endif
               end else begin
                  sh_n  = {1'b0, sh[7:1]};
                  tx_n  = sh[1];
                  bit_n = bit_cnt + 3'd1;
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               tx_n    = 1'b1;
               state_n = S_STOP;
            end
`endif
            S_STOP: begin
               // Chain straight into the next frame when another byte waits.
               if (!empty) begin
                  pop     = 1'b1;
                  sh_n    = mem[rd_ptr];
                  tx_n    = 1'b0;
                  state_n = S_START;
               end else begin
                  tx_n    = 1'b1;
                  state_n = S_IDLE;
               end
            end
            default: begin
               tx_n    = 1'b1;
               state_n = S_IDLE;
            end
         endcase
      end
   end

   assign bus.tx     = tx_reg;
   assign bus.clk_rx = rx_tick;
   assign bus.clk_tx = tx_tick;
   assign bus.full   = full;
   assign bus.empty  = empty;
   assign bus.busy   = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_tx_fifo_core : directed stimulus with a serial-line scoreboard     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_uart_tx_fifo_core;
   localparam int K  = 4;
   localparam int N  = 4;
   localparam int BP = K * N;
`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   cyc;
   bit   in_frame;
   logic [7:0] q [$];
   int   starts [$];

   uart_tx_fifo_core_if bif ();

   uart_tx_fifo_core #(.K(K), .N(N), .DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] d, input bit accept);
      @(posedge clk);
      #1;
      bif.wr_en = 1'b1;
      bif.data  = d;
      if (accept)
         q.push_back(d);
   endtask

   task automatic push_end();
      @(posedge clk);
      #1;
      bif.wr_en = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((q.size() != 0 || in_frame || bif.busy || !bif.empty) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({name, " drain timeout"}, (n < 3000) ? 32'd1 : 32'd0, 32'd1);
      @(negedge clk);
      check({name, " idle tx"}, {31'd0, bif.tx}, 32'd1);
      check({name, " idle busy"}, {31'd0, bif.busy}, 32'd0);
   endtask

   // Line monitor: decodes every frame and compares it with the next queued byte.
   initial begin
      logic [10:0] fb;
      logic [7:0]  d;
      logic        got;
      bit          abort;
      bit          mism;
      in_frame = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && bif.tx === 1'b0) begin
            if (q.size() == 0) begin
               check("unexpected frame", 32'd1, 32'd0);
               d = 8'hxx;
            end else begin
               d = q.pop_front();
            end
`ifdef UART_TX_PARITY_EN
            fb = {1'b1, ^d, d, 1'b0};
`else
            fb = {2'b11, d, 1'b0};
`endif
            in_frame = 1'b1;
            starts.push_back(cyc);
            abort = 1'b0;
            for (int b = 0; b < FB; b++) begin
               mism = 1'b0;
               got  = fb[b];
               for (int c = 0; c < BP; c++) begin
                  if (b != 0 || c != 0)
                     @(negedge clk);
                  if (rst) begin
                     abort = 1'b1;
                     break;
                  end
                  if (bif.tx !== fb[b] && !mism) begin
                     mism = 1'b1;
                     got  = bif.tx;
                  end
               end
               if (abort)
                  break;
               check($sformatf("frame %02h bit%0d", d, b), {31'd0, got}, {31'd0, fb[b]});
            end
            in_frame = 1'b0;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rx_pulses;
      int tx_pulses;
      int n;
      int glitches;
      total     = 0;
      bad       = 0;
      cyc       = 0;
      rst       = 1'b1;
      bif.wr_en = 1'b0;
      bif.data  = 8'h00;

      // 1: reset state and divider cadence
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset tx", {31'd0, bif.tx}, 32'd1);
      check("reset empty", {31'd0, bif.empty}, 32'd1);
      check("reset full", {31'd0, bif.full}, 32'd0);
      check("reset busy", {31'd0, bif.busy}, 32'd0);
      check("reset clk_rx", {31'd0, bif.clk_rx}, 32'd0);
      check("reset clk_tx", {31'd0, bif.clk_tx}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rx_pulses = 0;
      tx_pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bif.clk_rx) begin
            rx_pulses++;
            check($sformatf("clk_rx phase at %0d", i), i % 4, 3);
         end
         if (bif.clk_tx) begin
            tx_pulses++;
            check($sformatf("clk_tx phase at %0d", i), i % 16, 15);
         end
      end
      check("clk_rx pulse count", rx_pulses, 10);
      check("clk_tx pulse count", tx_pulses, 2);

      // 2: single byte from idle
      push(8'h55, 1'b1);
      push_end();
      @(negedge clk);
      check("empty after push", {31'd0, bif.empty}, 32'd0);
      wait_idle("t2");

      // 3: four queued bytes go out as contiguous frames
      starts.delete();
      push(8'h86, 1'b1);
      push(8'h8C, 1'b1);
      push(8'h8D, 1'b1);
      push(8'h9A, 1'b1);
      push_end();
      wait_idle("t3");
      check("t3 frame count", starts.size(), 4);
      for (int i = 1; i < 4 && i < starts.size(); i++)
         check($sformatf("t3 gap %0d", i), starts[i] - starts[i-1], FB * BP);

      // 4: overflow -- six pushes right after a tick, only four fit
      n = 0;
      while (bif.clk_tx !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t4 tick found", (n < 100) ? 32'd1 : 32'd0, 32'd1);
      push(8'h11, 1'b1);
      push(8'h22, 1'b1);
      push(8'h33, 1'b1);
      push(8'h44, 1'b1);
      push(8'h55, 1'b0);
      push(8'h66, 1'b0);
      push_end();
      @(negedge clk);
      check("t4 full", {31'd0, bif.full}, 32'd1);
      check("t4 empty", {31'd0, bif.empty}, 32'd0);
      wait_idle("t4");
      check("t4 full cleared", {31'd0, bif.full}, 32'd0);

      // 5: reset in the middle of a data bit
      push(8'hA5, 1'b1);
      push_end();
      n = 0;
      while (bif.tx !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t5 start seen", (n < 100) ? 32'd1 : 32'd0, 32'd1);
      repeat (35) @(negedge clk);
      check("t5 tx before reset", {31'd0, bif.tx}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("t5 tx after reset", {31'd0, bif.tx}, 32'd1);
      check("t5 empty after reset", {31'd0, bif.empty}, 32'd1);
      check("t5 busy after reset", {31'd0, bif.busy}, 32'd0);
      check("t5 queue", q.size(), 0);
      glitches = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bif.tx !== 1'b1)
            glitches++;
      end
      check("t5 line quiet", glitches, 0);
      push(8'h3C, 1'b1);
      push_end();
      wait_idle("t5 recovery");

`ifdef UART_TX_PARITY_EN
      // 6: even parity bit
      push(8'h07, 1'b1);
      push(8'h03, 1'b1);
      push_end();
      wait_idle("t6");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
